// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared types and constants for the multi-cycle CPU control unit
//   state_t     control FSM states IDLE, T0..T6
//   op_class_t  instruction classes resolved by ctrl_decode
//   OP_*        5-bit opcodes, *_HI/*_LO IR field positions, ALU_* one-hot bit indices
package cpu_ctrl_pkg;
   typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6} state_t;
   typedef enum logic [1:0] {OC_3OP, OC_MULDIV, OC_UNARY, OC_ILLEGAL} op_class_t;
   localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_SHR = 5'b00101,
                          OP_SHL = 5'b00110, OP_ROR = 5'b00111, OP_ROL = 5'b01000,
                          OP_AND = 5'b01001, OP_OR  = 5'b01010, OP_MUL = 5'b01110,
                          OP_DIV = 5'b01111, OP_NEG = 5'b10000, OP_NOT = 5'b10001;
   localparam int OPC_HI = 31, OPC_LO = 27, RA_HI = 26, RA_LO = 23;
   localparam int RB_HI = 22, RB_LO = 19, RC_HI = 18, RC_LO = 15;
   localparam int ALU_W = 12;
   localparam int ALU_ADD = 0, ALU_SUB = 1, ALU_MUL = 2, ALU_DIV = 3, ALU_SHR = 4, ALU_SHL = 5;
   localparam int ALU_ROR = 6, ALU_ROL = 7, ALU_AND = 8, ALU_OR = 9, ALU_NEG = 10, ALU_NOT = 11;
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: datapath-facing signals of the control unit
//   master: drives Run, Mem_rdy, IR; observes all strobes
//   slave : the control unit (consumes Run, Mem_rdy, IR; drives Rout/Rin, strobes, Alu_sel, Done, Illegal)
interface control_unit_if #(parameter int REGISTERS = 16, parameter int BITS = 32);
   logic                 Run, Mem_rdy;
   logic [BITS-1:0]      IR;
   logic [REGISTERS-1:0] Rout, Rin;
   logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, RYin, RZin, Zlowout, Zhighout, HIin, LOin;
   logic [11:0]          Alu_sel;
   logic                 Done, Illegal;
   modport master (output Run, Mem_rdy, IR,
                   input Rout, Rin, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, RYin, RZin,
                         Zlowout, Zhighout, HIin, LOin, Alu_sel, Done, Illegal);
   modport slave  (input Run, Mem_rdy, IR,
                   output Rout, Rin, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, RYin, RZin,
                          Zlowout, Zhighout, HIin, LOin, Alu_sel, Done, Illegal);
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational IR decode
//   ir       : opcode and register fields (IR[BITS-1:RC_LO])
//   op_class : 3-operand, mul/div, unary or illegal
//   alu_sel  : one-hot ALU operation
//   ra/rb/rc_sel : one-hot register selects for Ra, Rb, Rc
module ctrl_decode
   import cpu_ctrl_pkg::*;
#(
   parameter int REGISTERS = 16,
   parameter int BITS      = 32
) (
   input  logic [BITS-1:RC_LO]   ir,
   output op_class_t             op_class,
   output logic [ALU_W-1:0]      alu_sel,
   output logic [REGISTERS-1:0]  ra_sel,
   output logic [REGISTERS-1:0]  rb_sel,
   output logic [REGISTERS-1:0]  rc_sel
);
   logic [4:0] opc;
   assign opc    = ir[OPC_HI:OPC_LO];
   assign ra_sel = REGISTERS'(1) << ir[RA_HI:RA_LO];
   assign rb_sel = REGISTERS'(1) << ir[RB_HI:RB_LO];
   assign rc_sel = REGISTERS'(1) << ir[RC_HI:RC_LO];
   always_comb begin
      op_class = OC_ILLEGAL;
      alu_sel  = '0;
      case (opc)
         OP_ADD: begin op_class = OC_3OP;    alu_sel[ALU_ADD] = 1'b1; end
         OP_SUB: begin op_class = OC_3OP;    alu_sel[ALU_SUB] = 1'b1; end
         OP_SHR: begin op_class = OC_3OP;    alu_sel[ALU_SHR] = 1'b1; end
         OP_SHL: begin op_class = OC_3OP;    alu_sel[ALU_SHL] = 1'b1; end
         OP_ROR: begin op_class = OC_3OP;    alu_sel[ALU_ROR] = 1'b1; end
         OP_ROL: begin op_class = OC_3OP;    alu_sel[ALU_ROL] = 1'b1; end
         OP_AND: begin op_class = OC_3OP;    alu_sel[ALU_AND] = 1'b1; end
         OP_OR:  begin op_class = OC_3OP;    alu_sel[ALU_OR]  = 1'b1; end
         OP_MUL: begin op_class = OC_MULDIV; alu_sel[ALU_MUL] = 1'b1; end
         OP_DIV: begin op_class = OC_MULDIV; alu_sel[ALU_DIV] = 1'b1; end
         OP_NEG: begin op_class = OC_UNARY;  alu_sel[ALU_NEG] = 1'b1; end
         OP_NOT: begin op_class = OC_UNARY;  alu_sel[ALU_NOT] = 1'b1; end
         default: ;
      endcase
   end
endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/execute sequencer for the register-bus datapath
//   Clock, Resetn : rising-edge clock, asynchronous active-low reset
//   bus (slave)   : Run/Mem_rdy/IR in; register selects, datapath strobes, Alu_sel, Done, Illegal out
// All outputs are a Moore decode of state_q and IR; IDLE decodes to all-zero, so reset
// clears every output as soon as state_q is forced to IDLE.
module control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int REGISTERS = 16,
   parameter int BITS      = 32
) (
   input logic             Clock,
   input logic             Resetn,
   control_unit_if.slave   bus
);
   state_t                state_q, state_d, next_instr;
   op_class_t             op_class;
   logic [ALU_W-1:0]      alu_sel;
   logic [REGISTERS-1:0]  ra_sel, rb_sel, rc_sel;
   ctrl_decode #(.REGISTERS(REGISTERS), .BITS(BITS)) u_decode (
      .ir       (bus.IR[BITS-1:RC_LO]),
      .op_class (op_class),
      .alu_sel  (alu_sel),
      .ra_sel   (ra_sel),
      .rb_sel   (rb_sel),
      .rc_sel   (rc_sel)
   );
   // Where a completed instruction goes: Run is only sampled at completion.
   assign next_instr = bus.Run ? S_T0 : S_IDLE;
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end
   always_comb begin
      state_d      = state_q;
      bus.Rout     = '0;
      bus.Rin      = '0;
      bus.PCout    = 1'b0;
      bus.PCin     = 1'b0;
      bus.IncPC    = 1'b0;
      bus.MARin    = 1'b0;
      bus.MDRin    = 1'b0;
      bus.MDRout   = 1'b0;
      bus.Read     = 1'b0;
      bus.IRin     = 1'b0;
      bus.RYin     = 1'b0;
      bus.RZin     = 1'b0;
      bus.Zlowout  = 1'b0;
      bus.Zhighout = 1'b0;
      bus.HIin     = 1'b0;
      bus.LOin     = 1'b0;
      bus.Alu_sel  = '0;
      bus.Done     = 1'b0;
      bus.Illegal  = 1'b0;
      case (state_q)
         S_IDLE: state_d = bus.Run ? S_T0 : S_IDLE;
         S_T0: begin
            bus.PCout = 1'b1;
            bus.MARin = 1'b1;
            bus.IncPC = 1'b1;
            bus.RZin  = 1'b1;
            state_d   = S_T1;
         end
         S_T1: begin
            bus.Zlowout = 1'b1;
            bus.PCin    = 1'b1;
            bus.Read    = 1'b1;
            bus.MDRin   = 1'b1;
            state_d     = bus.Mem_rdy ? S_T2 : S_T1;
         end
         S_T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
            state_d    = S_T3;
         end
         S_T3: begin
            // MUL/DIV stage Ra into Y; other legal ops drive Rb; illegal drives nothing.
            bus.Rout    = (op_class == OC_MULDIV) ? ra_sel : (op_class == OC_ILLEGAL) ? '0 : rb_sel;
            bus.RYin    = (op_class == OC_3OP) || (op_class == OC_MULDIV);
            bus.RZin    = (op_class == OC_UNARY);
            bus.Alu_sel = (op_class == OC_UNARY) ? alu_sel : '0;
            bus.Illegal = (op_class == OC_ILLEGAL);
            state_d     = (op_class == OC_ILLEGAL) ? next_instr : S_T4;
         end
         S_T4: begin
            if (op_class == OC_UNARY) begin
               bus.Zlowout = 1'b1;
               bus.Rin     = ra_sel;
               bus.Done    = 1'b1;
               state_d     = next_instr;
            end else begin
               bus.Rout    = (op_class == OC_MULDIV) ? rb_sel : rc_sel;
               bus.Alu_sel = alu_sel;
               bus.RZin    = 1'b1;
               state_d     = S_T5;
            end
         end
         S_T5: begin
            bus.Zlowout = 1'b1;
            bus.LOin    = (op_class == OC_MULDIV);
            bus.Rin     = (op_class == OC_MULDIV) ? '0 : ra_sel;
            bus.Done    = (op_class != OC_MULDIV);
            state_d     = (op_class == OC_MULDIV) ? S_T6 : next_instr;
         end
         S_T6: begin
            bus.Zhighout = 1'b1;
            bus.HIin     = 1'b1;
            bus.Done     = 1'b1;
            state_d      = next_instr;
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized self-checking bench for control_unit against a cycle-sequence model
module tb_control_unit;
   import cpu_ctrl_pkg::*;
   localparam int PCO = 13, PCI = 12, INC = 11, MARI = 10, MDRI = 9, MDRO = 8, RD = 7;
   localparam int IRI = 6, RYI = 5, RZI = 4, ZLO = 3, ZHI = 2, HII = 1, LOI = 0;
   logic clk = 1'b0;
   logic rst_n;
   int vectors = 0;
   int errors = 0;
   logic [59:0] exp_q[$];
   logic [59:0] obs_q[$];
   logic [59:0] obs;
   // Opcode for each Alu_sel bit position 0..11.
   int alu_ops[12] = '{3, 4, 14, 15, 5, 6, 7, 8, 9, 10, 16, 17};
   always #5 clk = ~clk;
   control_unit_if #(.REGISTERS(16), .BITS(32)) bus ();
   control_unit #(.REGISTERS(16), .BITS(32)) dut (.Clock(clk), .Resetn(rst_n), .bus(bus));
   assign obs = {bus.Rout, bus.Rin, bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout,
                 bus.Read, bus.IRin, bus.RYin, bus.RZin, bus.Zlowout, bus.Zhighout, bus.HIin, bus.LOin,
                 bus.Alu_sel, bus.Done, bus.Illegal};
   function automatic logic [13:0] s(int b);
      return 14'(1) << b;
   endfunction
   function automatic logic [59:0] mk(logic [15:0] rout, logic [15:0] rin, logic [13:0] stb,
                                      logic [11:0] alu, logic dn, logic il);
      return {rout, rin, stb, alu, dn, il};
   endfunction
   function automatic logic [31:0] rand_ir();
      logic [31:0] r;
      r = $urandom;
      r[31:27] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'(alu_ops[$urandom_range(0, 11)]);
      return r;
   endfunction
   // Expected output per cycle, T0 through the last execute cycle.
   task automatic build(input logic [31:0] ir, input int waits);
      logic [15:0] ra, rb, rc;
      logic [11:0] alu;
      int k;
      ra = 16'(1) << ir[26:23];
      rb = 16'(1) << ir[22:19];
      rc = 16'(1) << ir[18:15];
      k = -1;
      for (int j = 0; j < 12; j++) if (alu_ops[j] == int'(ir[31:27])) k = j;
      alu = (k >= 0) ? 12'(1) << k : 12'h0;
      exp_q.delete();
      exp_q.push_back(mk(0, 0, s(PCO) | s(MARI) | s(INC) | s(RZI), 0, 0, 0));
      repeat (waits + 1) exp_q.push_back(mk(0, 0, s(ZLO) | s(PCI) | s(RD) | s(MDRI), 0, 0, 0));
      exp_q.push_back(mk(0, 0, s(MDRO) | s(IRI), 0, 0, 0));
      if (k < 0) begin
         exp_q.push_back(mk(0, 0, 0, 0, 0, 1));
      end else if (k == 2 || k == 3) begin
         exp_q.push_back(mk(ra, 0, s(RYI), 0, 0, 0));
         exp_q.push_back(mk(rb, 0, s(RZI), alu, 0, 0));
         exp_q.push_back(mk(0, 0, s(ZLO) | s(LOI), 0, 0, 0));
         exp_q.push_back(mk(0, 0, s(ZHI) | s(HII), 0, 1, 0));
      end else if (k >= 10) begin
         exp_q.push_back(mk(rb, 0, s(RZI), alu, 0, 0));
         exp_q.push_back(mk(0, ra, s(ZLO), 0, 1, 0));
      end else begin
         exp_q.push_back(mk(rb, 0, s(RYI), 0, 0, 0));
         exp_q.push_back(mk(rc, 0, s(RZI), alu, 0, 0));
         exp_q.push_back(mk(0, ra, s(ZLO), 0, 1, 0));
      end
   endtask
   // Runs one instruction; caller guarantees the next rising edge enters T0.
   // Run is held high for cycle indices below drop_at and low from there on.
   task automatic exec(input logic [31:0] ir, input int waits, input int drop_at);
      build(ir, waits);
      obs_q.delete();
      for (int i = 0; i < exp_q.size(); i++) begin
         @(posedge clk);
         @(negedge clk);
         obs_q.push_back(obs);
         if (i == 0) bus.IR = ir;
         bus.Mem_rdy = (i >= 1 && i <= waits) ? 1'b0 : (i == waits + 1) ? 1'b1 : 1'($urandom_range(0, 1));
         bus.Run = (i < drop_at);
      end
   endtask
   task automatic test_reset();
      repeat (2) @(negedge clk);
      vectors++;
      if (obs !== 60'h0 || dut.state_q !== S_IDLE) begin
         errors++;
         $display("FAIL reset: outputs %h state %0d, want 0 and IDLE", obs, dut.state_q);
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         vectors++;
         if (obs !== 60'h0) begin
            errors++;
            $display("FAIL idle_hold: outputs %h, want 0", obs);
         end
      end
   endtask
   task automatic test_and();
      bus.Run = 1'b1;
      exec(32'h4A920000, 0, 5);
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL and_seq cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (obs !== 60'h0) begin
         errors++;
         $display("FAIL and_idle: got %h want 0", obs);
      end
   endtask
   task automatic test_mem_wait();
      bus.Run = 1'b1;
      exec({5'b00011, 27'($urandom)}, 3, 99);
      exec({5'b01010, 27'($urandom)}, 1, 2);
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL mem_wait cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic test_mem_wait3();
      bus.Run = 1'b1;
      exec({5'b00100, 27'($urandom)}, 3, 4);
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL mem_wait3 cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic test_muldiv();
      bus.Run = 1'b1;
      exec(32'h71A00000, 0, 99);
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL mul_seq cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      exec({5'b01111, 27'($urandom)}, $urandom_range(0, 2), 6);
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL div_seq cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic test_illegal();
      bus.Run = 1'b1;
      exec(32'hF8000000, 0, 99);
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL illegal_seq cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      exec({5'b10001, 27'($urandom)}, 0, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL after_illegal cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (obs !== 60'h0) begin
         errors++;
         $display("FAIL illegal_idle: got %h want 0", obs);
      end
   endtask
   task automatic test_run_drop();
      bus.Run = 1'b1;
      exec({5'b00011, 27'($urandom)}, 0, 2);
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL run_drop cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         vectors++;
         if (obs !== 60'h0 || dut.state_q !== S_IDLE) begin
            errors++;
            $display("FAIL run_drop_idle: got %h state %0d want 0 IDLE", obs, dut.state_q);
         end
      end
   endtask
   task automatic test_async_reset();
      logic [31:0] ir;
      ir = {5'b00011, 27'($urandom)};
      build(ir, 0);
      bus.IR = ir;
      bus.Mem_rdy = 1'b1;
      bus.Run = 1'b1;
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
      end
      vectors++;
      if (obs !== exp_q[4]) begin
         errors++;
         $display("FAIL pre_reset_t4: got %h want %h", obs, exp_q[4]);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (obs !== 60'h0 || dut.state_q !== S_IDLE) begin
         errors++;
         $display("FAIL async_reset: got %h state %0d want 0 IDLE", obs, dut.state_q);
      end
      repeat (2) begin
         @(posedge clk);
         #1;
         vectors++;
         if (obs !== 60'h0) begin
            errors++;
            $display("FAIL reset_hold: got %h want 0", obs);
         end
      end
      @(negedge clk);
      bus.Run = 1'b0;
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         vectors++;
         if (obs !== 60'h0) begin
            errors++;
            $display("FAIL post_reset_idle: got %h want 0", obs);
         end
      end
      bus.Run = 1'b1;
      exec(ir, 0, 5);
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL post_reset_seq cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic test_back_to_back();
      bus.Run = 1'b1;
      for (int n = 0; n < 30; n++) begin
         exec(rand_ir(), $urandom_range(0, 3), (n == 29) ? 3 : 99);
         for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL b2b instr %0d cycle %0d: got %h want %h", n, i, obs_q[i], exp_q[i]);
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (obs !== 60'h0) begin
         errors++;
         $display("FAIL b2b_idle: got %h want 0", obs);
      end
   endtask
   initial begin
      rst_n = 1'b1;
      bus.Run = 1'b0;
      bus.Mem_rdy = 1'b0;
      bus.IR = 32'h0;
      #2 rst_n = 1'b0;
      test_reset();
      test_and();
      test_mem_wait();
      test_mem_wait3();
      test_muldiv();
      test_illegal();
      test_run_drop();
      test_async_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
